pixel_packer: RTL and testbench
===============================

PIXEL_PACKER -- requirements
Module: pixel_packer

Interface
REQ-001 Parameter: PIXEL_SIZE, 24, packed pixel width in bits.
REQ-002 Parameter: CHANNEL_SIZE, 8, byte/channel width in bits.
REQ-003 Parameter: DIM_BITS, 12, width of image dimension inputs.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: start  input  1  frame start request, sampled only in IDLE.
REQ-007 Port: img_width  input  DIM_BITS  pixels per row, latched on accepted start.
REQ-008 Port: img_height  input  DIM_BITS  rows per frame, latched on accepted start.
REQ-009 Port: in_valid  input  1  in_data holds a valid BMP pixel-array byte.
REQ-010 Port: in_data  input  CHANNEL_SIZE  byte from the BMP pixel array, file order.
REQ-011 Port: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-012 Port: out_en  output  1  one-cycle strobe, out_data holds a new pixel.
REQ-013 Port: out_data  output  PIXEL_SIZE  packed pixel for the downstream channel-swap stage.
REQ-014 Port: row_done  output  1  one-cycle pulse at the end of each row, padding included.
REQ-015 Port: frame_done  output  1  one-cycle pulse at the end of the frame.

Function
REQ-016 FSM states SHALL be IDLE, PIXEL and PAD; reset state SHALL be IDLE.
REQ-017 IDLE: in_ready=0; start=1 latches width and height; if either is zero, go to IDLE and pulse frame_done next cycle; otherwise go to PIXEL.
REQ-018 PIXEL: in_ready=1; each accepted byte goes to byte slot k (0,1,2), in bits [8k+7:8k]; the first file byte goes to [7:0].
REQ-019 On acceptance of slot-2 byte, out_data SHALL update and out_en SHALL pulse high in the following cycle (latency 1 cycle from third byte).
REQ-020 out_data SHALL hold its last value between strobes; out_en SHALL be high for exactly one cycle per pixel.
REQ-021 Row padding count SHALL be img_width mod 4 bytes (BMP 4-byte row alignment); the count SHALL be computed from the latched width.
REQ-022 After the last pixel of a row, go to PAD if padding > 0; otherwise end the row immediately.
REQ-023 PAD: in_ready=1; accepted bytes SHALL be discarded, with no out_en and no change to out_data.
REQ-024 Row end (last pixel byte with pad=0, or last pad byte): row_done SHALL pulse the following cycle; the column counter and slot counter SHALL clear.
REQ-025 Row end of row img_height-1: frame_done SHALL pulse in the same cycle as that row_done; the FSM SHALL go to IDLE.
REQ-026 Otherwise row end SHALL return to PIXEL for the next row.
REQ-027 in_valid=0 SHALL stall all counters and state with no output activity; gaps of any length SHALL be tolerated mid-pixel or mid-pad.
REQ-028 start asserted outside IDLE SHALL be ignored; img_width and img_height changes after latch SHALL have no effect.
REQ-029 Column counter width SHALL be DIM_BITS; row counter width SHALL be DIM_BITS; the maximum dimension is 2^DIM_BITS-1 with no wrap inside a frame.
REQ-030 IDLE with start=1 in the cycle frame_done pulses SHALL be accepted, so back-to-back frames are possible.

Reset
REQ-031 reset=1 SHALL force the state to IDLE and set in_ready=0, out_en=0, row_done=0, frame_done=0, out_data=0, and all counters and latched dimensions to 0.
REQ-032 Reset SHALL take precedence over all other inputs, including mid-pixel and mid-pad; partial pixel bytes SHALL be discarded and no strobe SHALL follow.

Verification
REQ-033 W=1,H=1, bytes 0x11,0x22,0x33,0xAA -> out_en once with out_data=0x332211; the 0xAA byte is dropped as pad; then row_done and frame_done pulse together.
REQ-034 W=4,H=2, 24 continuous bytes -> 8 out_en strobes, no pad, row_done after bytes 12 and 24, frame_done with the second row_done.
REQ-035 W=3,H=1, with in_valid deasserted for 5 cycles between bytes 2 and 3 and again mid-pad -> still 3 pixels and 3 pad bytes consumed, correct values, no spurious strobes.
REQ-036 W=2,H=2, reset asserted after byte 4 -> outputs are zero the next cycle, no further out_en; a restart with W=2,H=1 packs correctly from slot 0.
REQ-037 W=0,H=5 start -> no in_ready, and frame_done pulses once one cycle later.
REQ-038 start pulsed during PIXEL with different W/H -> ignored, and the frame completes with the originally latched dimensions.

Source files
------------

// File: rtl/pixel_packer_if.sv
// pixel_packer_if
// Groups the frame control, byte-stream input and pixel output of pixel_packer.
//   start       frame start request (only looked at while the packer is idle)
//   img_width   pixels per row, captured when a start is accepted
//   img_height  rows per frame, captured when a start is accepted
//   in_valid    in_data carries a BMP pixel-array byte
//   in_data     BMP pixel-array byte, file order
//   in_ready    packer takes the byte this cycle when in_valid is also high
//   out_en      one-cycle strobe: out_data holds a freshly packed pixel
//   out_data    packed pixel, first file byte in the least significant byte
//   row_done    one-cycle pulse after the last byte of a row (padding included)
//   frame_done  one-cycle pulse at the end of the frame
// The master modport is the side that feeds bytes; the slave is the packer.
interface pixel_packer_if #(
    parameter int PIXEL_SIZE   = 24,
    parameter int CHANNEL_SIZE = 8,
    parameter int DIM_BITS     = 12
);
    logic                    start;
    logic [DIM_BITS-1:0]     img_width;
    logic [DIM_BITS-1:0]     img_height;
    logic                    in_valid;
    logic [CHANNEL_SIZE-1:0] in_data;
    logic                    in_ready;
    logic                    out_en;
    logic [PIXEL_SIZE-1:0]   out_data;
    logic                    row_done;
    logic                    frame_done;

    modport master (
        output start, img_width, img_height, in_valid, in_data,
        input  in_ready, out_en, out_data, row_done, frame_done
    );

    modport slave (
        input  start, img_width, img_height, in_valid, in_data,
        output in_ready, out_en, out_data, row_done, frame_done
    );
endinterface

// File: rtl/pixel_packer.sv
// pixel_packer
// Packs the byte stream of a BMP pixel array into whole pixels. Each row is
// img_width pixels of PIXEL_SIZE/CHANNEL_SIZE bytes, followed by
// (img_width mod 4) padding bytes that are consumed and dropped.
//   clk    single clock, rising edge
//   reset  synchronous, active-high; returns to idle and clears everything
//   bus    pixel_packer_if slave: start/dimensions, byte input, pixel output
module pixel_packer #(
    parameter int PIXEL_SIZE   = 24,
    parameter int CHANNEL_SIZE = 8,
    parameter int DIM_BITS     = 12
) (
    input  logic         clk,
    input  logic         reset,
    pixel_packer_if.slave bus
);
    localparam int SLOTS  = PIXEL_SIZE / CHANNEL_SIZE;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int BUF_W  = PIXEL_SIZE - CHANNEL_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        PIXEL,
        PAD
    } state_t;

    state_t state, next_state;

    logic [DIM_BITS-1:0]   width_q;
    logic [DIM_BITS-1:0]   height_q;
    logic [DIM_BITS-1:0]   col;
    logic [DIM_BITS-1:0]   row;
    logic [SLOT_W-1:0]     slot;
    logic [1:0]            pad_cnt;
    logic [BUF_W-1:0]      pixel_buf;
    logic [PIXEL_SIZE-1:0] out_data_q;
    logic                  out_en_q;
    logic                  row_done_q;
    logic                  frame_done_q;
    logic                  ready;

    logic [1:0] pad_len;
    logic       accept;
    logic       last_slot;
    logic       last_col;
    logic       last_row;
    logic       last_pad;
    logic       dims_zero;

    // BMP rows are aligned to 4 bytes; with 3-byte pixels the pad is width mod 4.
    assign pad_len   = width_q[1:0];
    assign accept    = bus.in_valid && ready;
    assign last_slot = (slot == SLOT_W'(SLOTS - 1));
    assign last_col  = (col == width_q - 1'b1);
    assign last_row  = (row == height_q - 1'b1);
    assign last_pad  = (pad_cnt == pad_len - 2'd1);
    assign dims_zero = (bus.img_width == '0) || (bus.img_height == '0);

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start)
                    next_state = dims_zero ? IDLE : PIXEL;
            end
            PIXEL: begin
                ready = 1'b1;
                if (accept && last_slot && last_col) begin
                    if (pad_len != 2'd0)
                        next_state = PAD;
                    else
                        next_state = last_row ? IDLE : PIXEL;
                end
            end
            PAD: begin
                ready = 1'b1;
                if (accept && last_pad)
                    next_state = last_row ? IDLE : PIXEL;
            end
            default: next_state = IDLE;
        endcase
    end

    // Counters, byte buffer and registered output strobes. A partial pixel is
    // simply forgotten on reset because the slot counter restarts at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            width_q      <= '0;
            height_q     <= '0;
            col          <= '0;
            row          <= '0;
            slot         <= '0;
            pad_cnt      <= '0;
            pixel_buf    <= '0;
            out_data_q   <= '0;
            out_en_q     <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            out_en_q     <= 1'b0;
            row_done_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        width_q  <= bus.img_width;
                        height_q <= bus.img_height;
                        col      <= '0;
                        row      <= '0;
                        slot     <= '0;
                        pad_cnt  <= '0;
                        if (dims_zero)
                            frame_done_q <= 1'b1;
                    end
                end
                PIXEL: begin
                    if (accept) begin
                        if (last_slot) begin
                            out_data_q <= {bus.in_data, pixel_buf};
                            out_en_q   <= 1'b1;
                            slot       <= '0;
                            if (last_col) begin
                                col <= '0;
                                if (pad_len == 2'd0) begin
                                    row_done_q <= 1'b1;
                                    if (last_row)
                                        frame_done_q <= 1'b1;
                                    else
                                        row <= row + 1'b1;
                                end
                            end else begin
                                col <= col + 1'b1;
                            end
                        end else begin
                            for (int k = 0; k < SLOTS - 1; k++) begin
                                if (slot == SLOT_W'(k))
                                    pixel_buf[k*CHANNEL_SIZE +: CHANNEL_SIZE] <= bus.in_data;
                            end
                            slot <= slot + 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (accept) begin
                        if (last_pad) begin
                            pad_cnt    <= '0;
                            row_done_q <= 1'b1;
                            if (last_row)
                                frame_done_q <= 1'b1;
                            else
                                row <= row + 1'b1;
                        end else begin
                            pad_cnt <= pad_cnt + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_en     = out_en_q;
    assign bus.out_data   = out_data_q;
    assign bus.row_done   = row_done_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer
// Feeds BMP-style frames into pixel_packer and compares every pixel strobe,
// row pulse and frame pulse against events predicted from the frame layout.
module tb_pixel_packer;
    logic clk;
    logic reset;

    pixel_packer_if #(.PIXEL_SIZE(24), .CHANNEL_SIZE(8), .DIM_BITS(12)) pif ();

    pixel_packer #(.PIXEL_SIZE(24), .CHANNEL_SIZE(8), .DIM_BITS(12)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (pif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // kind 0: pixel strobe, 1: row end (fd = frame end too), 2: frame end alone
    typedef struct {
        int          kind;
        logic [23:0] data;
        bit          fd;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  frame_bytes[$];
    int          errors = 0;
    int          checks = 0;
    logic [23:0] last_data = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic fill_random(input int w, input int h);
        int stride;
        stride = 3 * w + (w % 4);
        frame_bytes.delete();
        for (int i = 0; i < stride * h; i++)
            frame_bytes.push_back(8'($urandom_range(0, 255)));
    endtask

    // Predict events from the file layout: pixel (r,c) starts at byte
    // r*stride + 3c, a row ends on its last byte; only events whose final byte
    // falls inside the first `limit` bytes are expected.
    task automatic expect_frame(input int w, input int h, input int limit);
        int  stride;
        int  base;
        ev_t e;
        stride = 3 * w + (w % 4);
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                base = r * stride + 3 * c;
                if (base + 2 < limit) begin
                    e.kind = 0;
                    e.data = {frame_bytes[base+2], frame_bytes[base+1], frame_bytes[base]};
                    e.fd   = 1'b0;
                    exp_q.push_back(e);
                end
            end
            if (r * stride + stride - 1 < limit) begin
                e.kind = 1;
                e.data = '0;
                e.fd   = (r == h - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic startFrame(input int w, input int h);
        pif.start      = 1'b1;
        pif.img_width  = 12'(w);
        pif.img_height = 12'(h);
        @(negedge clk);
        pif.start      = 1'b0;
        pif.img_width  = 12'($urandom);
        pif.img_height = 12'($urandom);
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        logic rdy;
        bit   got;
        got          = 0;
        pif.in_valid = 1'b1;
        pif.in_data  = b;
        for (int t = 0; t < 200; t++) begin
            rdy = pif.in_ready;
            @(negedge clk);
            if (rdy) begin
                got = 1;
                break;
            end
        end
        checkOutput("byte_accepted", 32'(got), 32'd1);
    endtask

    task automatic stall(input int n);
        pif.in_valid = 1'b0;
        pif.in_data  = 8'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input int stall_pct, input int gap_a, input int gap_b, input int limit);
        int n;
        n = (limit < 0) ? frame_bytes.size() : limit;
        for (int i = 0; i < n; i++) begin
            if (i == gap_a || i == gap_b)
                stall(5);
            else if (int'($urandom_range(0, 99)) < stall_pct)
                stall(int'($urandom_range(1, 3)));
            applyStimulus(frame_bytes[i]);
        end
        pif.in_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_out_en"},     32'(pif.out_en),     32'd0);
        checkOutput({tag, "_out_data"},   32'(pif.out_data),   32'd0);
        checkOutput({tag, "_row_done"},   32'(pif.row_done),   32'd0);
        checkOutput({tag, "_frame_done"}, 32'(pif.frame_done), 32'd0);
        checkOutput({tag, "_in_ready"},   32'(pif.in_ready),   32'd0);
    endtask

    // Monitor: pops the scoreboard whenever the packer shows activity and
    // checks that out_data never moves without a strobe.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (reset) begin
            last_data <= '0;
        end else begin
            if (pif.out_en) begin
                checkOutput("pixel_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("pixel_kind", 32'(e.kind), 32'd0);
                    checkOutput("pixel_data", 32'(pif.out_data), 32'(e.data));
                end
                last_data <= pif.out_data;
            end else begin
                checkOutput("out_data_hold", 32'(pif.out_data), 32'(last_data));
            end
            if (pif.row_done) begin
                checkOutput("row_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("row_kind", 32'(e.kind), 32'd1);
                    checkOutput("frame_with_row", 32'(pif.frame_done), 32'(e.fd));
                end
            end else if (pif.frame_done) begin
                checkOutput("frame_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    checkOutput("frame_kind", 32'(e.kind), 32'd2);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog time limit expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stimulus
        ev_t z;
        int  w;
        int  h;
        reset          = 1'b1;
        pif.start      = 1'b0;
        pif.img_width  = '0;
        pif.img_height = '0;
        pif.in_valid   = 1'b0;
        pif.in_data    = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        // 1x1 frame: one pixel, one pad byte dropped
        $display("[TB] 1x1 frame");
        frame_bytes = '{8'h11, 8'h22, 8'h33, 8'hAA};
        expect_frame(1, 1, 4);
        startFrame(1, 1);
        send_frame(0, -1, -1, -1);

        // 4x2, no padding, back-to-back with the previous frame
        $display("[TB] 4x2 frame");
        fill_random(4, 2);
        expect_frame(4, 2, 1000);
        startFrame(4, 2);
        send_frame(0, -1, -1, -1);

        // 3x1 with 5-cycle gaps mid-pixel and mid-pad
        $display("[TB] 3x1 frame with gaps");
        fill_random(3, 1);
        expect_frame(3, 1, 1000);
        startFrame(3, 1);
        send_frame(0, 2, 10, -1);
        repeat (2) @(negedge clk);

        // zero width: no data phase, frame_done one cycle later
        $display("[TB] zero-width frame");
        z.kind = 2;
        z.data = '0;
        z.fd   = 1'b0;
        exp_q.push_back(z);
        startFrame(0, 5);
        checkOutput("zero_dim_in_ready", 32'(pif.in_ready), 32'd0);
        checkOutput("zero_dim_frame_done", 32'(pif.frame_done), 32'd1);
        repeat (2) @(negedge clk);

        // reset after byte 4 of a 2x2 frame, then restart 2x1
        $display("[TB] reset mid-pixel");
        fill_random(2, 2);
        expect_frame(2, 2, 4);
        startFrame(2, 2);
        send_frame(0, -1, -1, 4);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset = 1'b0;
        repeat (3) @(negedge clk);
        fill_random(2, 1);
        expect_frame(2, 1, 1000);
        startFrame(2, 1);
        send_frame(0, -1, -1, -1);

        // start with other dimensions during PIXEL must be ignored
        $display("[TB] start ignored while busy");
        fill_random(3, 2);
        expect_frame(3, 2, 1000);
        startFrame(3, 2);
        send_frame(0, -1, -1, 4);
        pif.start      = 1'b1;
        pif.img_width  = 12'd5;
        pif.img_height = 12'd1;
        @(negedge clk);
        pif.start = 1'b0;
        for (int i = 4; i < frame_bytes.size(); i++)
            applyStimulus(frame_bytes[i]);
        pif.in_valid = 1'b0;

        // random frames with random stalls
        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            w = int'($urandom_range(1, 9));
            h = int'($urandom_range(1, 3));
            fill_random(w, h);
            expect_frame(w, h, 1000);
            startFrame(w, h);
            send_frame(30, -1, -1, -1);
            if ($urandom_range(0, 1) == 1)
                repeat (int'($urandom_range(1, 4))) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
